// File: rtl/cpu_run_supervisor.sv
// Run controller for the RISC-V cpu core: holds the core in reset, lets it run, and ends the
// run on a tohost store, a cycle timeout or a retire stall, latching the verdict and statistics.
module cpu_run_supervisor #(
  parameter int CPU_WIDTH      = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int STALL_CYCLES   = 256,
  parameter logic [CPU_WIDTH-1:0] TOHOST_ADDR = CPU_WIDTH'(32'h0000_1000)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mem_we,
  input  logic [CPU_WIDTH-1:0] mem_addr,
  input  logic [CPU_WIDTH-1:0] mem_wdata,
  input  logic                 retire,
  output logic                 cpu_reset_n,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           status,
  output logic [CPU_WIDTH-2:0] exit_code,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retire_count
);

  localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD    = HOLD_W'(RESET_CYCLES);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STALL_LAST   = CNT_WIDTH'(STALL_CYCLES - 1);
  localparam bit                   STALL_EN     = (STALL_CYCLES != 0);

  localparam logic [1:0] ST_PASS    = 2'b00;
  localparam logic [1:0] ST_FWFAIL  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_STALL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;

  logic       hit_tohost;
  logic       hit_timeout;
  logic       hit_stall;
  logic       term;
  logic [1:0] term_status;
  logic       term_pass;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  always_comb begin
    hit_tohost  = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    hit_timeout = (cycle_count == TIMEOUT_LAST);
    hit_stall   = STALL_EN && (stall_cnt == STALL_LAST) && !retire;
    term        = (state == S_RUN) && (hit_tohost || hit_timeout || hit_stall);
    term_pass   = 1'b0;
    term_status = ST_STALL;
    if (hit_tohost) begin
      term_pass   = (mem_wdata == CPU_WIDTH'(1));
      term_status = term_pass ? ST_PASS : ST_FWFAIL;
    end else if (hit_timeout) begin
      term_status = ST_TIMEOUT;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (start) state_next = S_RESET_HOLD;
      S_RESET_HOLD: if (hold_cnt == HOLD_W'(1)) state_next = S_RUN;
      S_RUN:        if (term) state_next = S_DONE;
      S_DONE:       if (start) state_next = S_RESET_HOLD;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt     <= '0;
      stall_cnt    <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      status       <= ST_PASS;
      exit_code    <= '0;
      pass         <= 1'b0;
      cpu_reset_n  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      cpu_reset_n <= (state_next == S_RUN);
      busy        <= (state_next == S_RESET_HOLD) || (state_next == S_RUN);
      done        <= (state_next == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            hold_cnt     <= HOLD_LOAD;
            stall_cnt    <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            status       <= ST_PASS;
            exit_code    <= '0;
            pass         <= 1'b0;
          end
        end
        S_RESET_HOLD: hold_cnt <= hold_cnt - 1'b1;
        S_RUN: begin
          cycle_count  <= sat_inc(cycle_count, 1'b1);
          retire_count <= sat_inc(retire_count, retire);
          stall_cnt    <= retire ? '0 : sat_inc(stall_cnt, 1'b1);
          if (term) begin
            status <= term_status;
            pass   <= term_pass;
            if (hit_tohost) exit_code <= mem_wdata[CPU_WIDTH-1:1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_supervisor.sv
// Randomised bench for cpu_run_supervisor: two instances (stall detection on and off) share
// the stimulus and are compared every cycle against a timeline model of a supervised run.
module tb_cpu_run_supervisor;

  localparam int RC = 4;
  localparam int TO = 100;
  localparam logic [31:0] TH = 32'h0000_1000;
  localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic reset, start, mem_we, retire;
  logic [31:0] mem_addr, mem_wdata;

  logic a_rn, a_busy, a_done, a_pass, b_rn, b_busy, b_done, b_pass;
  logic [1:0] a_status, b_status;
  logic [30:0] a_exit, b_exit;
  logic [31:0] a_cyc, a_ret, b_cyc, b_ret;

  int vec_cnt = 0;
  int err_cnt = 0;

  cpu_run_supervisor #(.CPU_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(RC),
    .TIMEOUT_CYCLES(TO), .STALL_CYCLES(8), .TOHOST_ADDR(TH)) dut_a (
    .clk(clk), .reset(reset), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .retire(retire), .cpu_reset_n(a_rn), .busy(a_busy),
    .done(a_done), .pass(a_pass), .status(a_status), .exit_code(a_exit),
    .cycle_count(a_cyc), .retire_count(a_ret));

  cpu_run_supervisor #(.CPU_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(RC),
    .TIMEOUT_CYCLES(TO), .STALL_CYCLES(0), .TOHOST_ADDR(TH)) dut_b (
    .clk(clk), .reset(reset), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .retire(retire), .cpu_reset_n(b_rn), .busy(b_busy),
    .done(b_done), .pass(b_pass), .status(b_status), .exit_code(b_exit),
    .cycle_count(b_cyc), .retire_count(b_ret));

  always #5 clk = ~clk;

  // Reference: phase of the run plus plain counts, advanced once per clock edge.
  int          m_ph[2];
  int          m_hold[2];
  longint      m_cyc[2], m_ret[2], m_stl[2];
  int          m_status[2];
  logic [30:0] m_exit[2];
  bit          m_pass[2];
  int          stall_lim[2] = '{8, 0};

  function automatic longint sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  function automatic void model_clear(input int i);
    m_cyc[i] = 0; m_ret[i] = 0; m_stl[i] = 0;
    m_status[i] = 0; m_exit[i] = '0; m_pass[i] = 0;
  endfunction

  function automatic void model_step(input int i);
    bit th, tmo, stl;
    if (reset) begin
      m_ph[i] = P_IDLE; m_hold[i] = 0; model_clear(i);
      return;
    end
    case (m_ph[i])
      P_IDLE, P_DONE: if (start) begin
        m_ph[i] = P_HOLD; m_hold[i] = RC; model_clear(i);
      end
      P_HOLD: begin
        m_hold[i]--;
        if (m_hold[i] == 0) m_ph[i] = P_RUN;
      end
      P_RUN: begin
        th  = mem_we && (mem_addr == TH) && mem_wdata[0];
        tmo = (m_cyc[i] == TO - 1);
        stl = (stall_lim[i] != 0) && (m_stl[i] == stall_lim[i] - 1) && !retire;
        m_cyc[i] = sat32(m_cyc[i] + 1);
        m_ret[i] = sat32(m_ret[i] + retire);
        m_stl[i] = retire ? 0 : sat32(m_stl[i] + 1);
        if (th) begin
          m_pass[i] = (mem_wdata == 32'd1);
          m_status[i] = m_pass[i] ? 0 : 1;
          m_exit[i] = mem_wdata[31:1];
          m_ph[i] = P_DONE;
        end else if (tmo) begin
          m_status[i] = 2; m_ph[i] = P_DONE;
        end else if (stl) begin
          m_status[i] = 3; m_ph[i] = P_DONE;
        end
      end
      default: m_ph[i] = P_IDLE;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input string p, input logic rn, input logic bz,
                            input logic dn, input logic ps, input logic [1:0] st,
                            input logic [30:0] ex, input logic [31:0] cc, input logic [31:0] rc);
    check_eq({p, ".cpu_reset_n"}, rn, m_ph[i] == P_RUN);
    check_eq({p, ".busy"}, bz, (m_ph[i] == P_HOLD) || (m_ph[i] == P_RUN));
    check_eq({p, ".done"}, dn, m_ph[i] == P_DONE);
    check_eq({p, ".pass"}, ps, m_pass[i]);
    check_eq({p, ".status"}, st, m_status[i][1:0]);
    check_eq({p, ".exit_code"}, ex, m_exit[i]);
    check_eq({p, ".cycle_count"}, cc, m_cyc[i][31:0]);
    check_eq({p, ".retire_count"}, rc, m_ret[i][31:0]);
  endtask

  task automatic drive(input bit r, input bit s, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit ret);
    reset = r; start = s; mem_we = we; mem_addr = a; mem_wdata = d; retire = ret;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_inst(0, "stall8", a_rn, a_busy, a_done, a_pass, a_status, a_exit, a_cyc, a_ret);
    check_inst(1, "stall0", b_rn, b_busy, b_done, b_pass, b_status, b_exit, b_cyc, b_ret);
  endtask

  // mode: 0 timeout, 1 tohost vs timeout, 2 ignored then failing store, 3 stall,
  // 4 reset mid-run, 5 random, 6 pass after 50 cycles with 40 retires
  task automatic run_scn(input int mode);
    bit r, s, we, ret, in_run, ended;
    logic [31:0] a, d;
    longint k;
    int tc, dens, n;
    tc = $urandom_range(0, 110);
    dens = $urandom_range(1, 4);
    ended = 0;
    drive(0, 1, 0, $urandom, $urandom, $urandom % 2);
    for (n = 0; n < 250 && !ended; n++) begin
      in_run = (m_ph[1] == P_RUN);
      k = m_cyc[1];
      r = 0; s = 0; we = 0; a = $urandom; d = $urandom; ret = 1;
      case (mode)
        1: if (in_run && k == 99) begin we = 1; a = TH; d = 32'd1; end
        2: if (in_run && k == 20) begin we = 1; a = TH; d = 32'd6; end
           else if (in_run && k == 40) begin we = 1; a = TH; d = 32'd7; end
        3: ret = !(k >= 20);
        4: if (in_run && k == 30) r = 1;
        5: begin
          ret = ($urandom % 4) < dens;
          we = ($urandom % 3) == 0;
          if (we && ($urandom % 2)) begin a = TH; d[0] = 1'b0; end
          if (in_run && k == tc) begin
            we = 1; a = TH;
            case ($urandom % 3)
              0: d = 32'd1;
              1: d = 32'd7;
              default: d = $urandom | 32'd1;
            endcase
          end
          s = (m_ph[0] == m_ph[1]) && (m_ph[0] == P_HOLD || m_ph[0] == P_RUN)
              && (($urandom % 16) == 0);
        end
        6: begin
          ret = (k % 5) != 4;
          if (in_run && k == 49) begin we = 1; a = TH; d = 32'd1; end
        end
        default: ;
      endcase
      drive(r, s, we, a, d, ret);
      if (r || (m_ph[0] == P_DONE && m_ph[1] == P_DONE)) ended = 1;
    end
    if (!ended) check_eq("run_terminated", b_done, 1'b1);
    for (int j = 0; j < 3; j++) drive(0, 0, $urandom % 2, TH, $urandom | 1, $urandom % 2);
  endtask

  initial begin
    int modes[14] = '{6, 2, 1, 0, 3, 4, 5, 5, 5, 5, 5, 5, 5, 5};
    reset = 1'b1; start = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; retire = 0;
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = P_IDLE; m_hold[i] = 0; model_clear(i);
    end
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    for (int c = 2; c < 10; c++) drive(0, 0, $urandom % 2, TH, $urandom, $urandom % 2);
    foreach (modes[m]) run_scn(modes[m]);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_run_supervisor.md
# cpu_run_supervisor

Synthesizable run controller for the RISC-V `cpu` core, the parametrised successor of the bench-level reset-and-watchdog logic. It holds the CPU in reset for a programmable number of cycles, then lets the CPU run. It ends the run on a firmware "tohost" store, a global cycle timeout, or a retire stall, and it latches a pass/fail verdict, an exit code and run statistics. It sits beside `cpu`, snooping the data-memory write port and the retire strobe, and drives the core's `a_reset_n`.

## Interface
- `CPU_WIDTH`, 32: data and address width of the snooped store bus.
- `CNT_WIDTH`, 32: width of the cycle and retire counters.
- `RESET_CYCLES`, 4: cycles `cpu_reset_n` is held low after `start`. Legal range is ≥1.
- `TIMEOUT_CYCLES`, 10000: maximum RUN cycles before a timeout verdict.
- `STALL_CYCLES`, 256: maximum consecutive RUN cycles without a retire. A value of 0 disables stall detection.
- `TOHOST_ADDR`, 32'h0000_1000: store address that ends the test.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a run. It is accepted only in IDLE or DONE.
- `mem_we` in 1: CPU data-memory write enable.
- `mem_addr` in CPU_WIDTH: CPU store address.
- `mem_wdata` in CPU_WIDTH: CPU store data.
- `retire` in 1: one instruction retired this cycle.
- `cpu_reset_n` out 1: drives `cpu.a_reset_n`. Low means the CPU is held in reset.
- `busy` out 1: high in RESET_HOLD or RUN.
- `done` out 1: high in DONE.
- `pass` out 1: verdict, valid while `done` is high.
- `status` out 2: 00 pass, 01 firmware fail, 10 timeout, 11 stall.
- `exit_code` out CPU_WIDTH-1: `mem_wdata[CPU_WIDTH-1:1]` of the terminating store.
- `cycle_count` out CNT_WIDTH: RUN cycles elapsed.
- `retire_count` out CNT_WIDTH: instructions retired in RUN.

## Operation
- FSM states: IDLE → RESET_HOLD → RUN → DONE. From DONE, a new `start` goes to RESET_HOLD.
- On `reset`, all outputs take these values:
  - state IDLE
  - `cpu_reset_n`=0
  - `busy`=0, `done`=0, `pass`=0
  - `status`=00, `exit_code`=0
  - both counters 0
- IDLE:
  - `cpu_reset_n`=0.
  - `start` moves to RESET_HOLD, loads the hold counter with RESET_CYCLES, and clears the counters, `status`, `exit_code` and `pass`.
- RESET_HOLD:
  - `cpu_reset_n`=0.
  - The hold counter decrements each cycle. When it reaches 1, the next state is RUN.
  - `start` is ignored.
- RUN:
  - `cpu_reset_n`=1.
  - `cycle_count` increments every cycle. `retire_count` increments when `retire`=1.
  - The stall counter clears on `retire` and otherwise increments.
- Termination is evaluated every RUN cycle. When several conditions hold in the same cycle, priority is tohost > timeout > stall:
  - **tohost**: `mem_we` && `mem_addr`==TOHOST_ADDR && `mem_wdata[0]`==1. The verdict is pass (status 00) when `mem_wdata`==1, otherwise firmware fail (status 01). `exit_code` latches `mem_wdata[CPU_WIDTH-1:1]`.
  - **tohost ignored**: a write to TOHOST_ADDR with `mem_wdata[0]`==0 does not end the run.
  - **timeout**: `cycle_count`==TIMEOUT_CYCLES-1 in this cycle. Status 10.
  - **stall**: STALL_CYCLES≠0 and the stall counter ==STALL_CYCLES-1 with `retire`=0. Status 11.
- DONE:
  - `cpu_reset_n`=0.
  - The verdict, status, exit code and counters are frozen until the next `start` or `reset`.
- Counter arithmetic is unsigned and saturates at all-ones; it never wraps.
- The cycle that triggers a termination is itself counted, including its retire.

## Timing
- `start` sampled in cycle T:
  - RESET_HOLD runs from T+1 through T+RESET_CYCLES.
  - `cpu_reset_n` rises at T+RESET_CYCLES+1, the first RUN cycle.
- A termination condition in RUN cycle R gives `done`=1, `busy`=0 and valid `pass`/`status`/`exit_code` from R+1. `cpu_reset_n` falls at R+1.
- The timeout triggers exactly TIMEOUT_CYCLES RUN cycles after RUN entry, so `cycle_count` reads TIMEOUT_CYCLES in DONE.
- `reset` mid-run forces IDLE on the next edge. `cpu_reset_n` is low at the next cycle and all outputs clear. `reset` takes priority over `start` in the same cycle.
- `start` in RUN is ignored. There is no restart until DONE.
- All outputs are registered, with no combinational input→output paths.

## Test plan
- Reset-length check:
  - Stimulus: RESET_CYCLES=4; `start` at cycle 10.
  - Response: `cpu_reset_n` low for cycles 11–14, high at 15, `busy`=1 from 11.
- Firmware pass:
  - Stimulus: store 32'h1 to 32'h1000 after 50 RUN cycles with 40 retires.
  - Response: `done`=1 the next cycle, `pass`=1, `status`=00, `cycle_count`=50, `retire_count`=40.
- Firmware fail:
  - Stimulus: store 32'h7 (test 3 failed) to TOHOST_ADDR.
  - Response: `status`=01, `pass`=0, `exit_code`=3.
  - Stimulus: a prior store of 32'h6 to the same address.
  - Response: ignored, the run continues.
- Timeout, with same-cycle priority:
  - Stimulus: TIMEOUT_CYCLES=100, `retire` every cycle, no tohost store.
  - Response: `status`=10, `cycle_count`=100.
  - Stimulus: a tohost store of 32'h1 in cycle 99.
  - Response: `status`=00, because tohost wins.
- Stall:
  - Stimulus: STALL_CYCLES=8; `retire` deasserted from RUN cycle 20.
  - Response: stall verdict, `status`=11, `done` at cycle 28.
  - Stimulus: STALL_CYCLES=0.
  - Response: the run ends by timeout only.
- Reset mid-run and restart:
  - Stimulus: `reset` in RUN cycle 30.
  - Response: next cycle IDLE, all outputs at their reset values.
  - Stimulus: `start` after DONE.
  - Response: counters and verdict clear, and a new reset pulse is generated.
